uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
- Host-facing end of the load-mode UART handshake.
- After the core has sent its 0xAA ready byte, this block consumes the host's byte stream: a 32-bit word count followed by that many 32-bit instruction words.
- It assembles the bytes into words and writes them sequentially into instruction memory from address 0.
- It then signals completion so the core can switch from LOAD to EXEC mode.
- It sits between uart_rx and the instruction BRAM write port.

Parameters:
- INST_SIZE, 10, instruction memory address width in words; capacity is 2**INST_SIZE words.
- BIG_ENDIAN, 1, 1 = first received byte is word bits [31:24]; 0 = first byte is bits [7:0].

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  level; load begins on the first cycle it is seen high while in IDLE (driven from aa_sent).
- rx_data  input  8  byte from uart_rx.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
- rx_ferr  input  1  framing error flag from uart_rx; sampled only when rx_valid=1.
- imem_we  output  1  one-cycle instruction memory write strobe.
- imem_addr  output  INST_SIZE  word address for the write.
- imem_wdata  output  32  assembled instruction word.
- busy  output  1  high in LEN and DATA states.
- load_done  output  1  sticky; high once every announced word has been written.
- load_err  output  1  sticky; high on a framing error or an oversize count.
- words_loaded  output  INST_SIZE+1  count of words written so far.

Behaviour:
- Reset (asynchronous, rstn=0):
  - All outputs go to 0; state = IDLE; byte counter, shift register and word count are cleared.
  - Reset asserted mid-load aborts the load immediately; no partial write is issued.
- States: IDLE, LEN, DATA, DONE, ERR.
- IDLE:
  - start=1 moves to LEN with byte counter = 0.
  - rx_valid in IDLE is ignored and the byte is dropped.
- LEN:
  - Each rx_valid shifts rx_data into a 32-bit shift register, ordered per BIG_ENDIAN; byte counter increments (2 bits, wraps 3 to 0).
  - When the 4th byte's rx_valid arrives, the word count N latches at the clock edge and the next state is decided:
    - N == 0: DONE.
    - N > 2**INST_SIZE: ERR.
    - otherwise: DATA.
- DATA:
  - Bytes are assembled the same way.
  - On the 4th byte's rx_valid edge, register the outputs: imem_wdata = word, imem_addr = words_loaded[INST_SIZE-1:0], imem_we = 1.
  - imem_we stays high for exactly one cycle, so write latency is 1 cycle after the last byte's rx_valid.
  - words_loaded increments in the same cycle imem_we is high.
  - When words_loaded reaches N after that increment, go to DONE.
- DONE:
  - load_done = 1; busy = 0.
  - Further bytes are ignored.
  - Leaving DONE requires reset.
- ERR:
  - load_err = 1; busy = 0; no further writes occur.
  - Leaving ERR requires reset.
- Framing error: rx_valid=1 with rx_ferr=1 in LEN or DATA goes to ERR. The offending byte is not shifted in and no write is issued for a partial word.
- start held high or re-pulsed outside IDLE has no effect.
- rx_valid arriving in the same cycle as imem_we is accepted normally. This requires back-to-back strobes to be at least 1 cycle apart, which uart_rx guarantees.
- The address never wraps: N ≤ 2**INST_SIZE is enforced in LEN, so the last address is 2**INST_SIZE−1.
- words_loaded is INST_SIZE+1 bits wide so it can hold 2**INST_SIZE.

Decomposition:
- Shared package (e.g. loader_pkg) holds:
  - the state enum {IDLE, LEN, DATA, DONE, ERR};
  - the READY_BYTE constant 8'hAA;
  - the word width constant 32.
- One natural sub-module: byte_assembler, containing the shift register, 2-bit byte counter and BIG_ENDIAN ordering. It outputs word and word_valid (1-cycle). It has a clear input used when entering LEN, DATA and ERR.
- The FSM, address/word counters and error logic stay in the top module.

Test Plan:
- Reset, start pulse, bytes 00 00 00 02 | 20 08 00 05 | 03 E0 00 08 (BIG_ENDIAN=1):
  - imem_we pulses twice: addr 0 / data 0x20080005, then addr 1 / data 0x03E00008;
  - each pulse 1 cycle after the 4th byte;
  - load_done=1, words_loaded=2, load_err=0.
- Bytes sent before start, then start followed by count 0 (00 00 00 00):
  - pre-start bytes ignored; no imem_we; load_done=1 on the edge of the 4th count byte.
- Count 0x00000401 with INST_SIZE=10: load_err=1, no writes, busy=0; subsequent bytes cause no writes.
- Count 1, then 3 data bytes followed by a byte with rx_ferr=1: load_err=1, no imem_we ever, words_loaded=0.
- Fill test, count 1024 with word i = i: last write at addr 1023, data 0x000003FF; words_loaded=1024; load_done=1.
- rstn driven low asynchronously after 2 of 4 data bytes:
  - all outputs 0 immediately, with no clock edge required;
  - after release, a new start plus a full stream loads correctly from addr 0.

Source files
------------

// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_program_loader_pkg;

  localparam int unsigned WORD_W = 32;

  // Byte the core sends to tell the host it is ready to receive a program.
  localparam logic [7:0] READY_BYTE = 8'hAA;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/uart_program_loader_byte_assembler.sv
// Packs a stream of bytes into 32-bit words.
// Ports:
//   clk, rstn     clock, async active-low reset
//   clear         zero shift register and byte counter
//   byte_valid    accept byte_data this cycle
//   byte_data     incoming byte
//   word_c        word including the byte currently presented
//   word_valid_c  high when the presented byte completes a word
module uart_program_loader_byte_assembler
  import uart_program_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word_c,
  output logic              word_valid_c
);

  logic [WORD_W-1:0] shift_q;
  logic [1:0]        cnt_q;

  // Combinational view lets the top register the write on the 4th byte's edge.
  always_comb begin
    word_c       = '0;
    word_valid_c = 1'b0;
    if (BIG_ENDIAN) begin
      word_c = {shift_q[WORD_W-9:0], byte_data};
    end else begin
      word_c = {byte_data, shift_q[WORD_W-1:8]};
    end
    word_valid_c = byte_valid && (cnt_q == 2'd3);
  end

  // Shift register and wrapping byte counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= word_c;
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Receives a word count plus that many instruction words over UART and
// writes them into instruction memory starting at address 0.
// Ports:
//   clk, rstn         clock, async active-low reset
//   start             begin a load when seen in IDLE
//   rx_data/rx_valid  byte stream from uart_rx
//   rx_ferr           framing error, qualified by rx_valid
//   imem_we/addr/wdata  one-cycle instruction memory write
//   busy              receiving count or data
//   load_done         sticky, all announced words written
//   load_err          sticky, framing error or oversize count
//   words_loaded      number of words written
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int unsigned INST_SIZE  = 10,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_ferr,
  output logic                 imem_we,
  output logic [INST_SIZE-1:0] imem_addr,
  output logic [WORD_W-1:0]    imem_wdata,
  output logic                 busy,
  output logic                 load_done,
  output logic                 load_err,
  output logic [INST_SIZE:0]   words_loaded
);

  localparam int unsigned CNT_W = INST_SIZE + 1;
  localparam logic [WORD_W:0] CAPACITY = (WORD_W+1)'(1) << INST_SIZE;

  state_t            state, state_next;
  logic [CNT_W-1:0]  n_words;
  logic [WORD_W-1:0] word_c;
  logic              word_valid_c;
  logic              byte_valid_c;
  logic              write_c;
  logic              clear_c;

  uart_program_loader_byte_assembler #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_asm (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (clear_c),
    .byte_valid   (byte_valid_c),
    .byte_data    (rx_data),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  // Next-state, byte acceptance and write decision.
  always_comb begin
    state_next   = state;
    byte_valid_c = 1'b0;
    write_c      = 1'b0;
    clear_c      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LEN;
      end
      LEN: begin
        if (rx_valid) begin
          if (rx_ferr) begin
            state_next = ERR;
          end else begin
            byte_valid_c = 1'b1;
            if (word_valid_c) begin
              if (word_c == '0)                       state_next = DONE;
              else if ({1'b0, word_c} > CAPACITY)     state_next = ERR;
              else                                    state_next = DATA;
            end
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          if (rx_ferr) begin
            state_next = ERR;
          end else begin
            byte_valid_c = 1'b1;
            write_c      = word_valid_c;
            if (word_valid_c && (words_loaded + CNT_W'(1) == n_words)) begin
              state_next = DONE;
            end
          end
        end
      end
      DONE:    state_next = DONE;
      ERR:     state_next = ERR;
      default: state_next = ERR;
    endcase
    if ((state_next != state) &&
        (state_next == LEN || state_next == DATA || state_next == ERR)) begin
      clear_c = 1'b1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      n_words      <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      state     <= state_next;
      imem_we   <= write_c;
      busy      <= (state_next == LEN) || (state_next == DATA);
      load_done <= (state_next == DONE);
      load_err  <= (state_next == ERR);
      if (state == LEN && word_valid_c && byte_valid_c) begin
        n_words <= word_c[CNT_W-1:0];
      end
      if (write_c) begin
        imem_addr    <= words_loaded[INST_SIZE-1:0];
        imem_wdata   <= word_c;
        words_loaded <= words_loaded + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ferr;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        load_done;
  logic        load_err;
  logic [10:0] words_loaded;

  int          n_chk;
  int          n_pass;
  int          wr_cnt;
  logic [9:0]  last_addr;
  logic [31:0] last_data;
  logic        last_we;

  uart_program_loader #(
    .INST_SIZE  (10),
    .BIG_ENDIAN (1'b1)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ferr      (rx_ferr),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .busy         (busy),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: records every imem write strobe.
  always @(posedge clk) begin
    #1;
    if (imem_we) begin
      wr_cnt    = wr_cnt + 1;
      last_addr = imem_addr;
      last_data = imem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    64'(imem_we), 64'd0);
    check({tag, "_addr"},  64'(imem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(load_done), 64'd0);
    check({tag, "_err"},   64'(load_err), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_ferr = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    wr_cnt = 0;
    rstn = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ferr);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1; rx_ferr = ferr;
    @(negedge clk);
    last_we = imem_we;
    rx_valid = 1'b0; rx_ferr = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8],  1'b0);
    send_byte(w[7:0],   1'b0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; wr_cnt = 0;
    last_addr = '0; last_data = '0; last_we = 1'b0;
    rstn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_ferr = 1'b0; rx_data = 8'h00;

    // Reset state
    do_reset();
    check_all_zero("rst");

    // Two-word big-endian load
    pulse_start();
    check("t1_busy_len", 64'(busy), 64'd1);
    send_word(32'h0000_0002);
    check("t1_busy_data", 64'(busy), 64'd1);
    check("t1_cnt_nowr", 64'(wr_cnt), 64'd0);
    send_word(32'h2008_0005);
    check("t1_we0_lat", 64'(last_we), 64'd1);
    check("t1_addr0", 64'(imem_addr), 64'd0);
    check("t1_data0", 64'(imem_wdata), 64'h2008_0005);
    check("t1_words1", 64'(words_loaded), 64'd1);
    @(negedge clk);
    check("t1_we_pulse", 64'(imem_we), 64'd0);
    send_word(32'h03E0_0008);
    check("t1_we1_lat", 64'(last_we), 64'd1);
    check("t1_addr1", 64'(imem_addr), 64'd1);
    check("t1_data1", 64'(imem_wdata), 64'h03E0_0008);
    @(negedge clk);
    check("t1_done", 64'(load_done), 64'd1);
    check("t1_words2", 64'(words_loaded), 64'd2);
    check("t1_err", 64'(load_err), 64'd0);
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_wrcnt", 64'(wr_cnt), 64'd2);

    // Bytes before start are dropped; zero count finishes immediately
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("t2_idle_busy", 64'(busy), 64'd0);
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("t2_not_done_yet", 64'(load_done), 64'd0);
    send_byte(8'h00, 1'b0);
    check("t2_done", 64'(load_done), 64'd1);
    check("t2_busy", 64'(busy), 64'd0);
    check("t2_wrcnt", 64'(wr_cnt), 64'd0);
    check("t2_words", 64'(words_loaded), 64'd0);

    // Oversize count
    do_reset();
    pulse_start();
    send_word(32'h0000_0401);
    check("t3_err", 64'(load_err), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    send_word(32'h1234_5678);
    pulse_start();
    send_word(32'h0000_0001);
    check("t3_wrcnt", 64'(wr_cnt), 64'd0);
    check("t3_err_sticky", 64'(load_err), 64'd1);
    check("t3_done", 64'(load_done), 64'd0);

    // Framing error on the 4th data byte
    do_reset();
    pulse_start();
    send_word(32'h0000_0001);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'h01, 1'b1);
    check("t4_err", 64'(load_err), 64'd1);
    check("t4_we", 64'(last_we), 64'd0);
    @(negedge clk);
    check("t4_wrcnt", 64'(wr_cnt), 64'd0);
    check("t4_words", 64'(words_loaded), 64'd0);
    check("t4_done", 64'(load_done), 64'd0);

    // Fill the whole memory
    do_reset();
    pulse_start();
    send_word(32'h0000_0400);
    for (int i = 0; i < 1024; i++) begin
      send_word(32'(i));
      if (i == 511) check("t5_mid_addr", 64'(imem_addr), 64'd511);
    end
    @(negedge clk);
    check("t5_last_addr", 64'(last_addr), 64'd1023);
    check("t5_last_data", 64'(last_data), 64'h3FF);
    check("t5_words", 64'(words_loaded), 64'd1024);
    check("t5_done", 64'(load_done), 64'd1);
    check("t5_wrcnt", 64'(wr_cnt), 64'd1024);
    check("t5_err", 64'(load_err), 64'd0);

    // Asynchronous reset mid-word, then a clean reload
    do_reset();
    pulse_start();
    send_word(32'h0000_0001);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    check("t6_busy_before", 64'(busy), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(negedge clk);
    check("t6_wrcnt", 64'(wr_cnt), 64'd0);
    rstn = 1'b1;
    pulse_start();
    send_word(32'h0000_0001);
    send_word(32'hDEAD_BEEF);
    check("t6_we", 64'(last_we), 64'd1);
    check("t6_addr", 64'(imem_addr), 64'd0);
    check("t6_data", 64'(imem_wdata), 64'hDEAD_BEEF);
    @(negedge clk);
    check("t6_done", 64'(load_done), 64'd1);
    check("t6_words", 64'(words_loaded), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
